// File: rtl/uesprit_corr_serializer_if.sv
// Valid/ready bundle between the unitary-ESPRIT correlation accumulator, the
// serializer and the readout/DoA stage.
interface uesprit_corr_serializer_if #(
    parameter int unsigned DIN_WIDTH  = 32,
    parameter int unsigned DROP_WIDTH = 16
);
    logic [DIN_WIDTH-1:0]  r11;
    logic [DIN_WIDTH-1:0]  r22;
    logic [DIN_WIDTH-1:0]  r12_re;
    logic [DIN_WIDTH-1:0]  r12_im;
    logic                  din_valid;
    logic [DIN_WIDTH-1:0]  dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [2:0]            dout_idx;
    logic                  dout_last;
    logic [DROP_WIDTH-1:0] drop_cnt;
    logic                  busy;

    modport master (
        output r11, r22, r12_re, r12_im, din_valid, dout_ready,
        input  dout, dout_valid, dout_idx, dout_last, drop_cnt, busy
    );

    modport slave (
        input  r11, r22, r12_re, r12_im, din_valid, dout_ready,
        output dout, dout_valid, dout_idx, dout_last, drop_cnt, busy
    );
endinterface

// File: rtl/uesprit_corr_serializer.sv
// Two-slot ping-pong capture of correlation snapshots, streamed one word per beat.
// Define UESPRIT_FRAME_CNT_EN to append a frame-counter word (5 words per snapshot).
module uesprit_corr_serializer #(
    parameter int unsigned DIN_WIDTH   = 32,
    parameter int unsigned DROP_WIDTH  = 16,
    parameter int unsigned FRAME_WIDTH = 32
) (
    input logic                     clk,
    input logic                     rst,
    uesprit_corr_serializer_if.slave bus
);

`ifdef UESPRIT_FRAME_CNT_EN
    localparam int unsigned NW = 5;
`else
    localparam int unsigned NW = 4;
`endif
    localparam logic [2:0] LastIdx = 3'(NW - 1);

    if (FRAME_WIDTH == 0) begin : g_frame_width_check
        $error("FRAME_WIDTH must be nonzero");
    end

    typedef enum logic {StIdle, StSend} state_e;

    state_e                state_q, state_d;
    logic [1:0]            full_q, full_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [2:0]            idx_q, idx_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
    logic [DIN_WIDTH-1:0]  slot_q [2][NW];
    logic [DIN_WIDTH-1:0]  slot_d [2][NW];
    logic [DIN_WIDTH-1:0]  snap   [NW];

    logic       accept;
    logic       accept_last;
    logic [1:0] full_free;
    logic       capture;
    logic       wr_sel;
    logic [DIN_WIDTH-1:0] word;

`ifdef UESPRIT_FRAME_CNT_EN
    logic [FRAME_WIDTH-1:0] frame_q, frame_d;

    always_comb begin
        frame_d = frame_q;
        if (bus.din_valid) begin
            frame_d = frame_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end
`endif

    always_comb begin
        snap[0] = bus.r11;
        snap[1] = bus.r22;
        snap[2] = bus.r12_re;
        snap[3] = bus.r12_im;
`ifdef UESPRIT_FRAME_CNT_EN
        snap[4] = DIN_WIDTH'(frame_q);
`endif
    end

    always_comb begin
        accept      = (state_q == StSend) && bus.dout_ready;
        accept_last = accept && (idx_q == LastIdx);

        // A slot released by this cycle's last-word accept is already usable for capture.
        full_free = full_q;
        if (accept_last) begin
            full_free[rd_ptr_q] = 1'b0;
        end
        capture = bus.din_valid && !(&full_free);
        wr_sel  = full_free[0];

        full_d = full_free;
        slot_d = slot_q;
        if (capture) begin
            full_d[wr_sel] = 1'b1;
            for (int i = 0; i < NW; i++) begin
                slot_d[wr_sel][i] = snap[i];
            end
        end

        // With one slot occupied it is the oldest; with both, keep the current reader.
        unique case (full_free)
            2'b01:   rd_ptr_d = 1'b0;
            2'b10:   rd_ptr_d = 1'b1;
            2'b11:   rd_ptr_d = rd_ptr_q;
            default: rd_ptr_d = 1'b0;
        endcase

        idx_d = idx_q;
        if (accept) begin
            idx_d = accept_last ? 3'd0 : idx_q + 3'd1;
        end

        drop_d = drop_q;
        if (bus.din_valid && !capture && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|full_d) state_d = StSend;
            StSend:  if (!(|full_d)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            full_q   <= '0;
            rd_ptr_q <= 1'b0;
            idx_q    <= '0;
            drop_q   <= '0;
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < NW; i++) begin
                    slot_q[s][i] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            full_q   <= full_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            drop_q   <= drop_d;
            slot_q   <= slot_d;
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < NW; i++) begin
            if (idx_q == 3'(i)) begin
                word = slot_q[rd_ptr_q][i];
            end
        end
    end

    assign bus.dout_valid = (state_q == StSend);
    assign bus.dout       = bus.dout_valid ? word : '0;
    assign bus.dout_idx   = idx_q;
    assign bus.dout_last  = bus.dout_valid && (idx_q == LastIdx);
    assign bus.drop_cnt   = drop_q;
    assign bus.busy       = |full_q;

endmodule

// File: tb/tb_uesprit_corr_serializer.sv
// Scoreboard bench for uesprit_corr_serializer: a queue-level snapshot model predicts
// accepted words and drops; a monitor compares every accepted beat.
module tb_uesprit_corr_serializer;
    localparam int unsigned DW  = 32;
    localparam int unsigned DRW = 4;
`ifdef UESPRIT_FRAME_CNT_EN
    localparam int NW = 5;
`else
    localparam int NW = 4;
`endif
    localparam int unsigned DROP_MAX = (1 << DRW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uesprit_corr_serializer_if #(.DIN_WIDTH(DW), .DROP_WIDTH(DRW)) bus ();

    uesprit_corr_serializer #(
        .DIN_WIDTH  (DW),
        .DROP_WIDTH (DRW),
        .FRAME_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [DW-1:0] w;
        logic [2:0]    idx;
        logic          last;
    } exp_t;

    exp_t        sb[$];
    int          m_cnt;    // snapshots held
    int          m_sent;   // words of head snapshot already accepted
    int unsigned m_drop;
    logic [31:0] m_frame;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: bounded queue of two snapshots, freeing before capturing.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   = 0;
            m_sent  = 0;
            m_drop  = 0;
            m_frame = '0;
            sb.delete();
        end else begin
            if (m_cnt > 0 && bus.dout_ready) begin
                m_sent++;
                if (m_sent == NW) begin
                    m_sent = 0;
                    m_cnt--;
                end
            end
            if (bus.din_valid) begin
                if (m_cnt < 2) begin
                    logic [DW-1:0] v [5];
                    v[0] = bus.r11;
                    v[1] = bus.r22;
                    v[2] = bus.r12_re;
                    v[3] = bus.r12_im;
                    v[4] = m_frame;
                    m_cnt++;
                    for (int i = 0; i < NW; i++) begin
                        sb.push_back('{w: v[i], idx: 3'(i), last: (i == NW - 1)});
                    end
                end else if (m_drop < DROP_MAX) begin
                    m_drop++;
                end
                m_frame = m_frame + 1;
            end
        end
    end

    // Monitor: mid-cycle, compares presented state and every accepted beat.
    always @(negedge clk) begin
        if (!rst) begin
            chk("dout_valid", bus.dout_valid, m_cnt > 0);
            chk("busy", bus.busy, m_cnt > 0);
            chk("drop_cnt", bus.drop_cnt, m_drop);
            if (bus.dout_valid && bus.dout_ready) begin
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("dout", bus.dout, e.w);
                    chk("dout_idx", bus.dout_idx, e.idx);
                    chk("dout_last", bus.dout_last, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [DW-1:0] a, b, c, d);
        bus.r11       = a;
        bus.r22       = b;
        bus.r12_re    = c;
        bus.r12_im    = d;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic rnd_pulse();
        pulse($urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.dout_ready = 1'b1;
        while (bus.busy && k < 100) begin
            tick();
            k++;
        end
        chk("drain_done", bus.busy, 0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_dout"}, bus.dout, 0);
        chk({tag, "_valid"}, bus.dout_valid, 0);
        chk({tag, "_idx"}, bus.dout_idx, 0);
        chk({tag, "_last"}, bus.dout_last, 0);
        chk({tag, "_drop"}, bus.drop_cnt, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        logic [DRW-1:0] drop_before;
        int k;
        bus.r11 = '0; bus.r22 = '0; bus.r12_re = '0; bus.r12_im = '0;
        bus.din_valid = 1'b0;
        bus.dout_ready = 1'b0;
        #12;
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // Single snapshot, always ready
        bus.dout_ready = 1'b1;
        pulse(32'd10, 32'd20, 32'hFFFF_FFFB, 32'd7);
        chk("t1_first_word", bus.dout, 32'd10);
        repeat (6) tick();

        // Backpressure with alternating ready
        for (int c = 0; c < 48; c++) begin
            bus.dout_ready = c[0];
            if (c % 12 == 0) begin
                rnd_pulse();
            end else begin
                tick();
            end
        end
        drain();

        // Three back-to-back pulses while stalled: third is dropped
        bus.dout_ready = 1'b0;
        rnd_pulse();
        rnd_pulse();
        rnd_pulse();
        repeat (3) tick();
        chk("t3_drop", bus.drop_cnt, 1);
        drain();

        // Capture coincident with last-word accept while both slots are full
        bus.dout_ready = 1'b0;
        rnd_pulse();
        rnd_pulse();
        drop_before = bus.drop_cnt;
        bus.dout_ready = 1'b1;
        k = 0;
        while (bus.dout_idx != 3'(NW - 1) && k < 20) begin
            tick();
            k++;
        end
        chk("t4_reached_last", bus.dout_idx, NW - 1);
        rnd_pulse();
        chk("t4_no_drop", bus.drop_cnt, drop_before);
        drain();

        // Asynchronous reset mid-snapshot
        bus.dout_ready = 1'b1;
        rnd_pulse();
        repeat (2) tick();
        chk("t5_idx_before_rst", bus.dout_idx, 2);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("t5");
        #2 rst = 1'b0;
        tick();
        rnd_pulse();
        drain();

        // Drop counter saturation
        bus.dout_ready = 1'b0;
        bus.din_valid  = 1'b1;
        repeat (2 + DROP_MAX + 6) begin
            bus.r11 = $urandom; bus.r22 = $urandom;
            bus.r12_re = $urandom; bus.r12_im = $urandom;
            tick();
        end
        bus.din_valid = 1'b0;
        tick();
        chk("sat_drop", bus.drop_cnt, DROP_MAX);
        drain();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            bus.dout_ready = $urandom_range(0, 1);
            bus.din_valid  = ($urandom_range(0, 3) == 0);
            bus.r11 = $urandom; bus.r22 = $urandom;
            bus.r12_re = $urandom; bus.r12_im = $urandom;
            tick();
        end
        bus.din_valid = 1'b0;
        drain();
        tick();
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
